hsv_top: RTL and testbench
==========================

// Module: hsv_top
// PURPOSE
//  Pipelined RGB565 -> HSV colour-space converter for the colour-detect path.
//  Accepts one pixel per clock and returns hue, saturation and value after a fixed latency.
//  Results leave in input order.
//  Sits between the camera pixel stream and the colour threshold/detect logic.
// PARAMETERS
//  LATENCY  20  i_valid-to-o_valid delay in cycles; fixed, informational, must stay 20
// PORTS
//  i_clk    in   1   clock, all logic on rising edge
//  i_rstn   in   1   reset, asynchronous, active-low
//  i_data   in   16  RGB565 pixel: [15:11]=R5, [10:5]=G6, [4:0]=B5
//  i_valid  in   1   i_data valid this cycle; no back-pressure
//  o_hue    out  16  hue in 1/64 degree, range 0..23039 (0..359.98 deg)
//  o_sat    out  16  saturation, 0..65535 full scale
//  o_value  out  8   value = max(R,G,B) in 8-bit
//  o_valid  out  1   outputs valid this cycle
// BEHAVIOUR
//  - Reset: i_rstn low clears all pipeline valid bits and all outputs to 0 immediately.
//    Reset mid-stream discards every in-flight pixel; none are emitted after release.
//  - Throughput 1 pixel/clk; pixel sampled at edge N appears with o_valid=1 at edge N+20.
//  - o_valid is i_valid delayed 20 cycles; gaps are preserved exactly.
//  - o_hue/o_sat/o_value are 0 whenever o_valid=0.
//  - Channel expansion to 8 bits: see CONFIGURATION.
//  - Core values: max=max(R,G,B), min=min(R,G,B), delta=max-min, value=max.
//  - sat: 0 if max==0, else floor(delta*65535/max); 24-bit numerator, 16-bit quotient.
//  - hue: 0 if delta==0.
//  - Dominant-channel priority on ties: R, then G, then B.
//  - Hue quotient: q=floor(3840*|d|/delta), where d is the signed difference below.
//  - R max: d=G-B; hue=q if d>=0, else 23040-q.
//  - G max: d=B-R; hue=7680+q if d>=0, else 7680-q.
//  - B max: d=R-G; hue=15360+q if d>=0, else 15360-q.
//  - Dividers: two unrolled restoring pipelines (sat, hue), 16 stages each, run in parallel.
//  - Stage map, edges counted from i_data capture: 1 capture, 2 expand, 3 max/min/delta,
//    4 numerators/sign, 5..20 divider stages.
//  - Hue offset/sign fix-up and output register are folded into stage 20.
//  - All arithmetic is unsigned except the sign flag of d; no overflow is possible.
// CONFIGURATION
//  HSV_EXPAND_EN
//    defined:   bit-replication expansion, R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]};
//               full-scale input gives 255.
//    undefined: zero-pad, R8={R5,3'b0}, G8={G6,2'b0}, B8={B5,3'b0};
//               full-scale R gives 248, G gives 252.
//  Latency is identical in both builds.
// TESTING (HSV_EXPAND_EN defined)
//  - Primaries:
//      0xF800 -> hue 0,     sat 65535, value 255
//      0x07E0 -> hue 7680,  sat 65535, value 255
//      0x001F -> hue 15360, sat 65535, value 255
//  - Greys:
//      0xFFFF -> hue 0, sat 0, value 255
//      0x0000 -> hue 0, sat 0, value 0
//  - Ties and wrap:
//      0xFFE0 yellow  -> hue 3840,  sat 65535, value 255
//      0xF81F magenta -> hue 19200, sat 65535, value 255
//      0x07FF cyan    -> hue 11520, sat 65535, value 255
//  - Streaming: 8 back-to-back valid pixels, then i_valid=0 ->
//      exactly 8 consecutive o_valid pulses starting 20 cycles after the first,
//      results in input order, no gaps.
//  - Reset: assert i_rstn low while 5 pixels are in flight, then release ->
//      outputs 0 immediately, o_valid never rises for those pixels.
//  - Build without HSV_EXPAND_EN: 0xF800 -> hue 0, sat 65535, value 248.

Source files
------------

// File: rtl/hsv_top.sv
// -----------------------------------------------------------------------------
// hsv_top - pipelined RGB565 to HSV colour-space converter
//
// Accepts one RGB565 pixel per clock and produces hue, saturation and value
// LATENCY (20) cycles later, in input order, with no back-pressure. Valid gaps
// on the input are reproduced exactly on the output.
//
// Pipeline (edges counted from pixel capture):
//   1      capture pixel
//   2      expand channels to 8 bits
//   3      max / min / delta, dominant channel (ties: R, then G, then B)
//   4      divider numerators, sign of the hue difference
//   5..20  two parallel 16-step restoring dividers (sat, hue); the last step,
//          the hue offset/sign fix-up and the output register share edge 20
//
// Build option:
//   HSV_EXPAND_EN  defined   -> bit-replication expansion (full scale = 255)
//                  undefined -> zero-pad expansion (full-scale R/B = 248, G = 252)
//
// Ports:
//   i_clk    in   1   clock, rising edge
//   i_rstn   in   1   asynchronous active-low reset
//   i_data   in   16  RGB565 pixel, [15:11]=R5 [10:5]=G6 [4:0]=B5
//   i_valid  in   1   i_data valid this cycle
//   o_hue    out  16  hue in 1/64 degree, 0..23039
//   o_sat    out  16  saturation, 0..65535
//   o_value  out  8   max(R,G,B) in 8 bits
//   o_valid  out  1   outputs valid this cycle (outputs are 0 otherwise)
// -----------------------------------------------------------------------------
module hsv_top #(
  parameter int LATENCY = 20
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  output logic [15:0] o_hue,
  output logic [15:0] o_sat,
  output logic [7:0]  o_value,
  output logic        o_valid
);

  // Four front-end stages, the rest are quotient bits.
  localparam int DIV_STEPS = LATENCY - 4;

  localparam logic [15:0] HUE_G     = 16'd7680;
  localparam logic [15:0] HUE_B     = 16'd15360;
  localparam logic [15:0] HUE_WRAP  = 16'd23040;
  localparam logic [23:0] HUE_SCALE = 24'd3840;

  typedef enum logic [1:0] {
    DOM_R = 2'd0,
    DOM_G = 2'd1,
    DOM_B = 2'd2
  } dom_e;

  // Per-pixel side information travelling alongside the dividers.
  typedef struct packed {
    logic [7:0] value;
    logic       max_zero;
    logic       delta_zero;
    logic       neg;
    dom_e       dom;
  } side_t;

  // Restoring-divider state: partial remainder, remaining numerator bits that
  // are progressively replaced by quotient bits, and the divisor.
  typedef struct packed {
    logic [7:0]  rem;
    logic [15:0] work;
    logic [7:0]  div;
  } div_t;

  // The numerator's top byte is always below the divisor (quotient < 2^16),
  // so the remainder never needs more than 8 bits between steps.
  function automatic logic div_ge(input div_t s);
    return {s.rem, s.work[15]} >= {1'b0, s.div};
  endfunction

  function automatic div_t div_step(input div_t s);
    div_t       n;
    logic [8:0] shifted;
    shifted = {s.rem, s.work[15]};
    n.div   = s.div;
    if (div_ge(s)) begin
      // Modulo-256 subtraction is exact here: the true result is below div.
      n.rem  = shifted[7:0] - s.div;
      n.work = {s.work[14:0], 1'b1};
    end else begin
      n.rem  = shifted[7:0];
      n.work = {s.work[14:0], 1'b0};
    end
    return n;
  endfunction

  // Final step only needs the quotient, not the remainder.
  function automatic logic [15:0] div_quot(input div_t s);
    return {s.work[14:0], div_ge(s)};
  endfunction

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic [LATENCY-2:0] vld_q;          // vld_q[k] = valid of pipeline stage k+1

  logic [15:0] pix_q;                 // stage 1
  logic [7:0]  r8_d, g8_d, b8_d;
  logic [7:0]  r8_q, g8_q, b8_q;      // stage 2
  dom_e        dom_d, dom_q;
  logic [7:0]  max_d, min_d, delta_d, da_d, db_d;
  logic [7:0]  max_q, delta_q, da_q, db_q;  // stage 3, d = da - db

  logic        neg_d;
  logic [7:0]  absd_d;
  logic [23:0] hue_num_d, sat_num_d;
  div_t        sat_d0, hue_d0;
  side_t       side_d0;

  div_t        sat_q  [DIV_STEPS];    // index 0 = stage 4, index k = stage 4+k
  div_t        hue_q  [DIV_STEPS];
  side_t       side_q [DIV_STEPS];

  side_t       side_last;
  logic [15:0] hue_quot, sat_quot;
  logic [15:0] hue_d, sat_d;

  // ---------------------------------------------------------------------------
  // Stage 2: channel expansion
  // ---------------------------------------------------------------------------
`ifdef HSV_EXPAND_EN
  assign r8_d = {pix_q[15:11], pix_q[15:13]};
  assign g8_d = {pix_q[10:5],  pix_q[10:9]};
  assign b8_d = {pix_q[4:0],   pix_q[4:2]};
`else
  assign r8_d = {pix_q[15:11], 3'b000};
  assign g8_d = {pix_q[10:5],  2'b00};
  assign b8_d = {pix_q[4:0],   3'b000};
`endif

  // ---------------------------------------------------------------------------
  // Stage 3: dominant channel, max/min/delta and the hue difference operands
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    dom_d = DOM_R;
    max_d = r8_q;
    da_d  = g8_q;
    db_d  = b8_q;
    if (!(r8_q >= g8_q && r8_q >= b8_q)) begin
      if (g8_q >= b8_q) begin
        dom_d = DOM_G;
        max_d = g8_q;
        da_d  = b8_q;
        db_d  = r8_q;
      end else begin
        dom_d = DOM_B;
        max_d = b8_q;
        da_d  = r8_q;
        db_d  = g8_q;
      end
    end
    min_d = r8_q;
    if (g8_q < min_d) min_d = g8_q;
    if (b8_q < min_d) min_d = b8_q;
    delta_d = max_d - min_d;
  end

  // ---------------------------------------------------------------------------
  // Stage 4: numerators, |d| and its sign
  // ---------------------------------------------------------------------------
  always_comb begin
    neg_d     = da_q < db_q;
    absd_d    = neg_d ? (db_q - da_q) : (da_q - db_q);
    hue_num_d = {16'd0, absd_d} * HUE_SCALE;
    // delta * 65535 without a second multiplier.
    sat_num_d = {delta_q, 16'd0} - {16'd0, delta_q};

    sat_d0.rem  = sat_num_d[23:16];
    sat_d0.work = sat_num_d[15:0];
    sat_d0.div  = max_q;
    hue_d0.rem  = hue_num_d[23:16];
    hue_d0.work = hue_num_d[15:0];
    hue_d0.div  = delta_q;

    side_d0.value      = max_q;
    side_d0.max_zero   = (max_q == 8'd0);
    side_d0.delta_zero = (delta_q == 8'd0);
    side_d0.neg        = neg_d;
    side_d0.dom        = dom_q;
  end

  // ---------------------------------------------------------------------------
  // Stage 20: last divider step plus hue offset / sign fix-up
  // ---------------------------------------------------------------------------
  always_comb begin
    side_last = side_q[DIV_STEPS-1];
    hue_quot  = div_quot(hue_q[DIV_STEPS-1]);
    sat_quot  = div_quot(sat_q[DIV_STEPS-1]);
    hue_d     = '0;
    case (side_last.dom)
      DOM_R:   hue_d = side_last.neg ? (HUE_WRAP - hue_quot) : hue_quot;
      DOM_G:   hue_d = side_last.neg ? (HUE_G - hue_quot) : (HUE_G + hue_quot);
      default: hue_d = side_last.neg ? (HUE_B - hue_quot) : (HUE_B + hue_quot);
    endcase
    // Grey pixels divide by zero; their garbage quotients are overridden here.
    if (side_last.delta_zero) hue_d = '0;
    sat_d = side_last.max_zero ? 16'd0 : sat_quot;
  end

  // ---------------------------------------------------------------------------
  // Control path and outputs: reset clears everything in flight
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_q   <= '0;
      o_valid <= 1'b0;
      o_hue   <= '0;
      o_sat   <= '0;
      o_value <= '0;
    end else begin
      vld_q   <= {vld_q[LATENCY-3:0], i_valid};
      o_valid <= vld_q[LATENCY-2];
      o_hue   <= vld_q[LATENCY-2] ? hue_d : 16'd0;
      o_sat   <= vld_q[LATENCY-2] ? sat_d : 16'd0;
      o_value <= vld_q[LATENCY-2] ? side_last.value : 8'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Data path
  // ---------------------------------------------------------------------------
  // NOTE: data registers carry no reset; nothing downstream trusts them unless
  // the matching valid bit is set, and the outputs are gated by that bit.
  always_ff @(posedge i_clk) begin
    pix_q   <= i_data;
    r8_q    <= r8_d;
    g8_q    <= g8_d;
    b8_q    <= b8_d;
    dom_q   <= dom_d;
    max_q   <= max_d;
    delta_q <= delta_d;
    da_q    <= da_d;
    db_q    <= db_d;

    sat_q[0]  <= sat_d0;
    hue_q[0]  <= hue_d0;
    side_q[0] <= side_d0;
    for (int k = 1; k < DIV_STEPS; k++) begin
      sat_q[k]  <= div_step(sat_q[k-1]);
      hue_q[k]  <= div_step(hue_q[k-1]);
      side_q[k] <= side_q[k-1];
    end
  end

endmodule

// File: tb/tb_hsv_top.sv
// -----------------------------------------------------------------------------
// tb_hsv_top - self-checking bench for hsv_top
//
// Table of hand-computed vectors (both expansion builds, chosen by
// HSV_EXPAND_EN), streamed back-to-back with one idle slot, then hand-written
// sequences for streaming order/contiguity and mid-stream reset.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_hsv_top;

  localparam int LAT = 20;
  localparam int NV  = 12;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b1;
  logic [15:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic [15:0] o_hue;
  logic [15:0] o_sat;
  logic [7:0]  o_value;
  logic        o_valid;

  hsv_top dut (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_hue   (o_hue),
    .o_sat   (o_sat),
    .o_value (o_value),
    .o_valid (o_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] data;
    logic        valid;
    logic [15:0] hue;
    logic [15:0] sat;
    logic [7:0]  value;
  } vec_t;

  vec_t vecs [NV];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [15:0] d, input logic v,
                         input logic [15:0] h, input logic [15:0] s,
                         input logic [7:0] val);
    vecs[i].data  = d;
    vecs[i].valid = v;
    vecs[i].hue   = h;
    vecs[i].sat   = s;
    vecs[i].value = val;
  endtask

  task automatic check_out(input string tag, input vec_t e);
    check({tag, " valid"}, 32'(o_valid), 32'(e.valid));
    check({tag, " hue"},   32'(o_hue),   32'(e.hue));
    check({tag, " sat"},   32'(o_sat),   32'(e.sat));
    check({tag, " value"}, 32'(o_value), 32'(e.value));
  endtask

  task automatic drive(input vec_t v);
    i_data  = v.data;
    i_valid = v.valid;
  endtask

  task automatic drive_idle();
    i_data  = '0;
    i_valid = 1'b0;
  endtask

  vec_t idle_exp;
  int   stream_idx [8] = '{0, 1, 2, 4, 5, 6, 7, 8};

  initial begin
    int   first, last, cnt;
    vec_t px;

    idle_exp = '{data: 16'h0, valid: 1'b0, hue: 16'd0, sat: 16'd0, value: 8'd0};

    //             idx data      v  hue    sat    value
`ifdef HSV_EXPAND_EN
    set_vec( 0, 16'hF800, 1, 0,     65535, 255);
    set_vec( 1, 16'h07E0, 1, 7680,  65535, 255);
    set_vec( 2, 16'h001F, 1, 15360, 65535, 255);
    set_vec( 3, 16'hF800, 0, 0,     0,     0);
    set_vec( 4, 16'hFFFF, 1, 0,     0,     255);
    set_vec( 5, 16'h0000, 1, 0,     0,     0);
    set_vec( 6, 16'hFFE0, 1, 3840,  65535, 255);
    set_vec( 7, 16'hF81F, 1, 19200, 65535, 255);
    set_vec( 8, 16'h07FF, 1, 11520, 65535, 255);
    set_vec( 9, 16'h8410, 1, 19200, 992,   132);
    set_vec(10, 16'hA284, 1, 1396,  52428, 165);
    set_vec(11, 16'h129E, 1, 14280, 61289, 247);
`else
    set_vec( 0, 16'hF800, 1, 0,     65535, 248);
    set_vec( 1, 16'h07E0, 1, 7680,  65535, 252);
    set_vec( 2, 16'h001F, 1, 15360, 65535, 248);
    set_vec( 3, 16'hF800, 0, 0,     0,     0);
    set_vec( 4, 16'hFFFF, 1, 7680,  1040,  252);
    set_vec( 5, 16'h0000, 1, 0,     0,     0);
    set_vec( 6, 16'hFFE0, 1, 3901,  65535, 252);
    set_vec( 7, 16'hF81F, 1, 19200, 65535, 248);
    set_vec( 8, 16'h07FF, 1, 11459, 65535, 252);
    set_vec( 9, 16'h8410, 1, 0,     0,     128);
    set_vec(10, 16'hA284, 1, 1440,  52428, 160);
    set_vec(11, 16'h129E, 1, 14263, 61166, 240);
`endif

    // ---- reset state ----
    #2 i_rstn = 1'b0;
    #1 check_out("reset", idle_exp);
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b1;

    // ---- table: back-to-back with one idle slot, checked LAT cycles later ----
    for (int c = 0; c < NV + LAT + 2; c++) begin
      @(negedge i_clk);
      if (c >= LAT && c - LAT < NV)
        check_out($sformatf("vec%0d", c - LAT), vecs[c - LAT]);
      else
        check_out($sformatf("idle%0d", c), idle_exp);
      if (c < NV) drive(vecs[c]);
      else        drive_idle();
    end

    // ---- streaming: 8 back-to-back pixels, order and contiguity ----
    first = -1; last = -1; cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_valid) begin
        if (first < 0) first = c;
        if (cnt < 8) check_out($sformatf("stream%0d", cnt), vecs[stream_idx[cnt]]);
        cnt++;
        last = c;
      end
      if (c < 8) drive(vecs[stream_idx[c]]);
      else       drive_idle();
    end
    check("stream first cycle", 32'(first), 32'(LAT));
    check("stream pulse count", 32'(cnt), 32'd8);
    check("stream span", 32'(last - first + 1), 32'd8);

    // ---- mid-stream reset: outputs clear at once, in-flight pixels dropped ----
    px = vecs[0];
    for (int c = 0; c < 22; c++) begin
      @(negedge i_clk);
      drive(px);
    end
    @(negedge i_clk);
    check("pre-reset valid", 32'(o_valid), 32'd1);
    i_rstn = 1'b0;
    drive_idle();
    #1 check_out("async reset", idle_exp);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    cnt = 0;
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge i_clk);
      if (o_valid) cnt++;
    end
    check("post-reset valid pulses", 32'(cnt), 32'd0);

    // ---- recovery: a single pixel after reset emerges on time ----
    first = -1;
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge i_clk);
      if (o_valid && first < 0) begin
        first = c;
        check_out("recovery", vecs[2]);
      end
      if (c == 0) drive(vecs[2]);
      else        drive_idle();
    end
    check("recovery latency", 32'(first), 32'(LAT));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
